ofmap_bit_packer: RTL and testbench



---
 rtl/ofmap_bit_packer.sv | 164 ++++++++++++++++
 tb/tb_ofmap_bit_packer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_bit_packer.sv
// Packs 1-bit activation results into BRAM words and issues masked word writes.
// On end-of-layer it flushes any partial word and pulses o_done.
module ofmap_bit_packer #(
    parameter int OFMAPS_BRAM_ADDR_WIDTH = 12,
    parameter int OFMAPS_BRAM_DATA_WIDTH = 32,
    parameter int LANE_BITS              = 5
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_data,
    input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0]           i_addr,
    input  logic                                        i_valid,
    input  logic                                        i_last,
    output logic                                        bram_en,
    output logic [OFMAPS_BRAM_ADDR_WIDTH-LANE_BITS-1:0] bram_addr,
    output logic [OFMAPS_BRAM_DATA_WIDTH-1:0]           bram_wdata,
    output logic [OFMAPS_BRAM_DATA_WIDTH-1:0]           bram_wmask,
    output logic                                        o_done,
    output logic [15:0]                                 o_word_cnt
);

    localparam int AW  = OFMAPS_BRAM_ADDR_WIDTH;
    localparam int W   = OFMAPS_BRAM_DATA_WIDTH;
    localparam int WAW = AW - LANE_BITS;

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                r_state;
    logic [W-1:0]          r_acc_data;
    logic [W-1:0]          r_acc_mask;
    logic [WAW-1:0]        r_acc_waddr;
    logic                  r_pend;

    logic                  r_bram_en;
    logic [WAW-1:0]        r_bram_addr;
    logic [W-1:0]          r_bram_wdata;
    logic [W-1:0]          r_bram_wmask;
    logic                  r_done;
    logic [15:0]           r_word_cnt;

    logic [WAW-1:0]        w_wa;
    logic [LANE_BITS-1:0]  w_lane;
    logic [W-1:0]          w_onehot;
    logic                  w_chg;
    logic                  w_keep;
    logic [W-1:0]          w_base_data;
    logic [W-1:0]          w_base_mask;
    logic [W-1:0]          w_mrg_data;
    logic [W-1:0]          w_mrg_mask;
    logic                  w_full;

    logic                  w_wr;
    logic [WAW-1:0]        w_wr_addr;
    logic [W-1:0]          w_wr_data;
    logic [W-1:0]          w_wr_mask;
    logic                  w_done;
    logic [15:0]           w_cnt_base;
    logic [15:0]           w_cnt_nxt;

    assign w_wa     = i_addr[AW-1:LANE_BITS];
    assign w_lane   = i_addr[LANE_BITS-1:0];
    assign w_onehot = {{(W-1){1'b0}}, 1'b1} << w_lane;
    assign w_chg    = r_pend && (w_wa != r_acc_waddr);
    assign w_keep   = r_pend && !w_chg;

    // Without a pending word the accumulator content is stale, so merge onto zero.
    assign w_base_data = w_keep ? r_acc_data : '0;
    assign w_base_mask = w_keep ? r_acc_mask : '0;
    assign w_mrg_data  = i_data ? (w_base_data | w_onehot) : (w_base_data & ~w_onehot);
    assign w_mrg_mask  = w_base_mask | w_onehot;
    assign w_full      = &w_mrg_mask;

    always_comb begin
        w_wr      = 1'b0;
        w_wr_addr = r_acc_waddr;
        w_wr_data = r_acc_data;
        w_wr_mask = r_acc_mask;
        w_done    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (i_valid) begin
                    if (w_chg) begin
                        w_wr = 1'b1;
                    end else if (w_full) begin
                        w_wr      = 1'b1;
                        w_wr_addr = w_wa;
                        w_wr_data = w_mrg_data;
                        w_wr_mask = w_mrg_mask;
                    end
                end
            end
            S_FLUSH: begin
                w_wr   = r_pend;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // The count restarts the cycle after o_done; a write landing that cycle still counts.
    assign w_cnt_base = r_done ? '0 : r_word_cnt;
    assign w_cnt_nxt  = (w_wr && (w_cnt_base != '1)) ? (w_cnt_base + 16'd1) : w_cnt_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_acc_data   <= '0;
            r_acc_mask   <= '0;
            r_acc_waddr  <= '0;
            r_pend       <= 1'b0;
            r_bram_en    <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_wdata <= '0;
            r_bram_wmask <= '0;
            r_done       <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            r_bram_en    <= w_wr;
            r_bram_addr  <= w_wr ? w_wr_addr : '0;
            r_bram_wdata <= w_wr ? w_wr_data : '0;
            r_bram_wmask <= w_wr ? w_wr_mask : '0;
            r_done       <= w_done;
            r_word_cnt   <= w_cnt_nxt;

            case (r_state)
                S_RUN: begin
                    if (i_valid) begin
                        r_acc_waddr <= w_wa;
                        if (w_full) begin
                            r_pend     <= 1'b0;
                            r_acc_data <= '0;
                            r_acc_mask <= '0;
                        end else begin
                            r_pend     <= 1'b1;
                            r_acc_data <= w_mrg_data;
                            r_acc_mask <= w_mrg_mask;
                        end
                    end
                    if (i_last) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_pend     <= 1'b0;
                    r_acc_data <= '0;
                    r_acc_mask <= '0;
                    r_state    <= S_RUN;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign bram_en    = r_bram_en;
    assign bram_addr  = r_bram_addr;
    assign bram_wdata = r_bram_wdata;
    assign bram_wmask = r_bram_wmask;
    assign o_done     = r_done;
    assign o_word_cnt = r_word_cnt;

endmodule

// File: tb/tb_ofmap_bit_packer.sv
// Bench for ofmap_bit_packer: directed scenarios plus random traffic against a
// lane-list reference model that predicts each cycle's outputs.
module tb_ofmap_bit_packer;

    localparam int AW  = 12;
    localparam int W   = 32;
    localparam int LB  = 5;
    localparam int WAW = AW - LB;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_data;
    logic [AW-1:0]  i_addr;
    logic           i_valid;
    logic           i_last;
    logic           bram_en;
    logic [WAW-1:0] bram_addr;
    logic [W-1:0]   bram_wdata;
    logic [W-1:0]   bram_wmask;
    logic           o_done;
    logic [15:0]    o_word_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: each lane holds -1 (unwritten), 0 or 1.
    int         lane_val[W];
    int         m_wa;
    bit         m_has;
    bit         m_flush;
    int         m_cnt;
    bit         m_prev_done;
    bit         e_en;
    int         e_addr;
    logic [W-1:0] e_wd;
    logic [W-1:0] e_wm;
    bit         e_done;

    ofmap_bit_packer #(
        .OFMAPS_BRAM_ADDR_WIDTH(AW),
        .OFMAPS_BRAM_DATA_WIDTH(W),
        .LANE_BITS(LB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_data(i_data),
        .i_addr(i_addr),
        .i_valid(i_valid),
        .i_last(i_last),
        .bram_en(bram_en),
        .bram_addr(bram_addr),
        .bram_wdata(bram_wdata),
        .bram_wmask(bram_wmask),
        .o_done(o_done),
        .o_word_cnt(o_word_cnt)
    );

    always #5 clk = ~clk;

    function automatic void clear_lanes();
        for (int n = 0; n < W; n++) lane_val[n] = -1;
    endfunction

    function automatic void emit(int wa);
        e_en   = 1'b1;
        e_addr = wa;
        for (int n = 0; n < W; n++) begin
            if (lane_val[n] >= 0) begin
                e_wm[n] = 1'b1;
                e_wd[n] = (lane_val[n] == 1);
            end
        end
        clear_lanes();
    endfunction

    function automatic void model_step(bit r, bit v, bit d, int a, bit l);
        bit all_set;
        int wa;
        int ln;
        e_en = 0; e_addr = 0; e_wd = '0; e_wm = '0; e_done = 0;
        if (r) begin
            clear_lanes();
            m_has = 0; m_flush = 0; m_cnt = 0; m_prev_done = 0; m_wa = 0;
            return;
        end
        if (m_flush) begin
            if (m_has) emit(m_wa);
            m_has   = 0;
            e_done  = 1;
            m_flush = 0;
        end else begin
            if (v) begin
                wa = a / W;
                ln = a % W;
                if (m_has && wa != m_wa) emit(m_wa);
                lane_val[ln] = d ? 1 : 0;
                m_wa  = wa;
                m_has = 1;
                all_set = 1;
                for (int n = 0; n < W; n++) if (lane_val[n] < 0) all_set = 0;
                if (all_set) begin
                    emit(m_wa);
                    m_has = 0;
                end
            end
            if (l) m_flush = 1;
        end
        if (m_prev_done) m_cnt = 0;
        if (e_en && m_cnt < 65535) m_cnt++;
        m_prev_done = e_done;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit d, input int a, input bit l);
        rst     = r;
        i_valid = v;
        i_data  = d;
        i_addr  = AW'(a);
        i_last  = l;
        model_step(r, v, d, a, l);
        @(posedge clk);
        #1;
        chk("bram_en",    64'(bram_en),    64'(e_en));
        chk("bram_addr",  64'(bram_addr),  64'(e_addr));
        chk("bram_wdata", 64'(bram_wdata), 64'(e_wd));
        chk("bram_wmask", 64'(bram_wmask), 64'(e_wm));
        chk("o_done",     64'(o_done),     64'(e_done));
        chk("o_word_cnt", 64'(o_word_cnt), 64'(m_cnt));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int seq;
        int a;
        rst = 1; i_valid = 0; i_data = 0; i_addr = '0; i_last = 0;
        clear_lanes();
        m_has = 0; m_flush = 0; m_cnt = 0; m_prev_done = 0; m_wa = 0;
        #2;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_en",  64'(bram_en),    64'd0);
        chk("reset_cnt", 64'(o_word_cnt), 64'd0);

        // Full word of alternating bits
        for (int i = 0; i < 32; i++) step(0, 1, (i % 2) == 0, i, 0);
        chk("t1_en",    64'(bram_en),    64'd1);
        chk("t1_addr",  64'(bram_addr),  64'd0);
        chk("t1_wdata", 64'(bram_wdata), 64'h5555_5555);
        chk("t1_wmask", 64'(bram_wmask), 64'hFFFF_FFFF);
        chk("t1_cnt",   64'(o_word_cnt), 64'd1);

        // Partial word evicted by address change, then flush
        for (int i = 32; i < 36; i++) step(0, 1, 1, i, 0);
        step(0, 1, 1, 96, 0);
        chk("t2_addr",  64'(bram_addr),  64'd1);
        chk("t2_wdata", 64'(bram_wdata), 64'h0000_000F);
        chk("t2_wmask", 64'(bram_wmask), 64'h0000_000F);
        step(0, 0, 0, 0, 1);
        chk("t2_nodone_t1", 64'(o_done), 64'd0);
        idle();
        chk("t2_flush_en",   64'(bram_en),    64'd1);
        chk("t2_flush_addr", 64'(bram_addr),  64'd3);
        chk("t2_flush_wd",   64'(bram_wdata), 64'h1);
        chk("t2_flush_done", 64'(o_done),     64'd1);
        idle();
        chk("t2_cnt_clr", 64'(o_word_cnt), 64'd0);

        // i_last with nothing pending
        step(0, 0, 0, 0, 1);
        idle();
        chk("t3_done", 64'(o_done),  64'd1);
        chk("t3_en",   64'(bram_en), 64'd0);
        idle();

        // Address change coincident with i_last
        step(0, 1, 1, 40, 0);
        step(0, 1, 1, 64, 1);
        chk("t4_addr1",  64'(bram_addr),  64'd1);
        chk("t4_wdata1", 64'(bram_wdata), 64'h100);
        idle();
        chk("t4_addr2", 64'(bram_addr), 64'd2);
        chk("t4_done",  64'(o_done),    64'd1);
        idle();

        // Lane rewritten: latest value wins
        step(0, 1, 1, 5, 0);
        step(0, 1, 0, 5, 0);
        step(0, 0, 0, 0, 1);
        idle();
        chk("t5_wdata", 64'(bram_wdata), 64'h0);
        chk("t5_wmask", 64'(bram_wmask), 64'h20);
        idle();

        // Reset mid-word discards partial data
        for (int i = 0; i < 10; i++) step(0, 1, 1, i, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        idle();
        chk("t6_done", 64'(o_done),  64'd1);
        chk("t6_en",   64'(bram_en), 64'd0);
        idle();

        // Random traffic mixing sequential fills and scattered addresses
        seq = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = seq % 4096;
                seq++;
            end else begin
                a = int'($urandom_range(0, 255));
            end
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1,
                 a,
                 ($urandom_range(0, 39) == 0));
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
